mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the pipelined RV32I core, between the EX/MEM register and write-back. It aligns store data and generates byte enables, and it runs a request/ready handshake with the data memory, holding the pipeline through wait states. It also traps misaligned accesses. It owns the MEM/WB pipeline register that feeds write-back: the raw load word plus byte offset, funct3, ALU result, PC+4, rd and write controls.

## Interface
- WIDTH, 32, data/address width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_EXMEM  in  1  EX/MEM slot holds a live instruction
- ALU_out_EXMEM  in  32  effective address (loads/stores) or ALU result
- rs2_data_EXMEM  in  32  store source
- pc_4_EXMEM  in  32  PC+4
- funct3_EXMEM  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- mem_rd_en_EXMEM, mem_wr_en_EXMEM  in  1 each  load / store (never both)
- reg_wr_ctrl_EXMEM  in  2  0=ALU, 1=PC+4, 2=memory
- rd_EXMEM  in  5  destination register
- reg_wr_en_EXMEM  in  1  register write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address ({ALU_out[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready & ~dmem_we
- mem_stall  out  1  freeze IF..EX/MEM this cycle
- misalign  out  1  one-cycle pulse: misaligned access trapped
- ALU_out_MEMWB, pc_4_MEMWB, mem_rd_data_MEMWB  out  32 each
- funct3_MEMWB  out  3
- byte_offset_MEMWB  out  2
- reg_wr_ctrl_MEMWB  out  2
- rd_MEMWB  out  5
- reg_wr_en_MEMWB  out  1

## Operation
- Access = valid_EXMEM & (mem_rd_en | mem_wr_en). off = ALU_out[1:0].
- Misaligned: half with off[0]=1, or word with off!=0. Such an access issues no request. It pulses misalign, and MEM/WB gets reg_wr_en=0.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<off.
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<off.
  - SW: wdata=rs2, be=4'b1111.
  - Loads: be=4'b1111, dmem_we=0.
- FSM, two states:
  - IDLE:
    - Aligned access drives dmem_req=1 combinationally from EX/MEM fields.
    - If dmem_ready is also high, the access completes and the state stays IDLE.
    - Otherwise go to WAIT, with mem_stall=1.
  - WAIT:
    - dmem_req=1 with addr/we/be/wdata held; they derive from the EX/MEM inputs, which are frozen by the stall.
    - mem_stall=1 until the cycle dmem_ready=1, when the access completes and the FSM returns to IDLE with mem_stall=0.
- MEM/WB load each cycle:
  - Completing or non-memory instruction: copy all fields. mem_rd_data_MEMWB takes dmem_rdata on load completion and keeps its old value otherwise. byte_offset_MEMWB=off.
  - Stalled cycle (mem_stall=1): bubble, reg_wr_en_MEMWB=0; other fields don't care.
  - valid_EXMEM=0: bubble.
- Stores force reg_wr_en_MEMWB=0 regardless of input.
- Load-result masking and sign extension happen in write-back, not here.

## Timing
- Reset (async assert, sync release) state:
  - FSM=IDLE.
  - All MEM/WB outputs are 0, including reg_wr_en_MEMWB.
  - dmem_req=0, mem_stall=0, misalign=0.
- Zero-wait access: request and completion in cycle N, with MEM/WB valid at N+1.
- Access with k wait states: mem_stall is high for k cycles, and MEM/WB is valid the cycle after dmem_ready.
- dmem_req stays high continuously from issue to ready. The request fields must not change while it is high.
- Back-to-back accesses: a new request may issue in the cycle immediately after completion, with no idle gap.
- dmem_ready while dmem_req=0 is ignored.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately, dmem_req drops, and the pending access is abandoned.
- misalign is combinational with the EX/MEM instruction and never coincides with dmem_req.

## Test plan
- SW x at addr 0x100, rs2=0xDEADBEEF, ready same cycle:
  - dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, no stall.
  - reg_wr_en_MEMWB=0 next cycle.
- SB at 0x103, rs2=0x000000A5:
  - be=1000, wdata=0xA5A5A5A5.
- LH at 0x202 with ready delayed 3 cycles and rdata=0x8001_1234:
  - mem_stall high for exactly 3 cycles, with bubbles in MEM/WB.
  - Then mem_rd_data_MEMWB=0x80011234, byte_offset_MEMWB=2, funct3=LH, reg_wr_ctrl=2.
- LW at 0x305:
  - No dmem_req; misalign pulses one cycle; reg_wr_en_MEMWB=0.
  - Next instruction proceeds unstalled.
- Load in WAIT, rst_n pulled low:
  - dmem_req and mem_stall go 0 asynchronously, all MEM/WB outputs are 0, and the FSM is in IDLE after release.
- ADD result 0x55 to rd=7, then JAL with pc_4=0x44 to rd=1:
  - Consecutive MEM/WB cycles carry ALU_out=0x55/ctrl 0, then pc_4=0x44/ctrl 1.
  - No dmem_req on either.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: store lane alignment, byte enables, req/ready handshake with
// data memory, misalignment trap, and the MEM/WB pipeline register.
module mem_access #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_EXMEM,
    input  logic [WIDTH-1:0] ALU_out_EXMEM,
    input  logic [WIDTH-1:0] rs2_data_EXMEM,
    input  logic [WIDTH-1:0] pc_4_EXMEM,
    input  logic [2:0]       funct3_EXMEM,
    input  logic             mem_rd_en_EXMEM,
    input  logic             mem_wr_en_EXMEM,
    input  logic [1:0]       reg_wr_ctrl_EXMEM,
    input  logic [4:0]       rd_EXMEM,
    input  logic             reg_wr_en_EXMEM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             mem_stall,
    output logic             misalign,
    output logic [WIDTH-1:0] ALU_out_MEMWB,
    output logic [WIDTH-1:0] pc_4_MEMWB,
    output logic [WIDTH-1:0] mem_rd_data_MEMWB,
    output logic [2:0]       funct3_MEMWB,
    output logic [1:0]       byte_offset_MEMWB,
    output logic [1:0]       reg_wr_ctrl_MEMWB,
    output logic [4:0]       rd_MEMWB,
    output logic             reg_wr_en_MEMWB
);

    localparam int unsigned BE_W  = 4;
    localparam int unsigned OFF_W = 2;
    localparam int unsigned RD_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;

    logic               access_c;
    logic               misaligned_c;
    logic               aligned_c;
    logic [OFF_W-1:0]   off_c;
    logic [1:0]         size_c;
    logic [WIDTH-1:0]   wdata_c;
    logic [BE_W-1:0]    be_c;
    logic               req_c;
    logic               stall_c;
    logic               complete_c;

    logic [WIDTH-1:0]   alu_q, alu_d;
    logic [WIDTH-1:0]   pc4_q, pc4_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic [2:0]         f3_q, f3_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic               wen_q, wen_d;

    // Access classification and misalignment detection
    always_comb begin
        access_c     = valid_EXMEM & (mem_rd_en_EXMEM | mem_wr_en_EXMEM);
        off_c        = ALU_out_EXMEM[OFF_W-1:0];
        size_c       = funct3_EXMEM[1:0];
        misaligned_c = 1'b0;
        if (access_c) begin
            if (size_c == 2'b01) begin
                misaligned_c = off_c[0];
            end else if (size_c[1]) begin
                misaligned_c = (off_c != 2'b00);
            end
        end
        aligned_c = access_c & ~misaligned_c;
    end

    // Store lane replication and byte enables; loads read the full word
    always_comb begin
        wdata_c = rs2_data_EXMEM;
        be_c    = 4'b1111;
        if (mem_wr_en_EXMEM) begin
            case (size_c)
                2'b00: begin
                    wdata_c = {4{rs2_data_EXMEM[7:0]}};
                    be_c    = 4'(4'b0001 << off_c);
                end
                2'b01: begin
                    wdata_c = {2{rs2_data_EXMEM[15:0]}};
                    be_c    = 4'(4'b0011 << off_c);
                end
                default: begin
                    wdata_c = rs2_data_EXMEM;
                    be_c    = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake FSM; reset forces the request and stall low immediately
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        complete_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_c) begin
                    req_c = 1'b1;
                    if (dmem_ready) begin
                        complete_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (dmem_ready) begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!rst_n) begin
            req_c      = 1'b0;
            stall_c    = 1'b0;
            complete_c = 1'b0;
            state_d    = ST_IDLE;
        end
    end

    assign dmem_req   = req_c;
    assign dmem_we    = mem_wr_en_EXMEM;
    assign dmem_addr  = {ALU_out_EXMEM[WIDTH-1:OFF_W], 2'b00};
    assign dmem_wdata = wdata_c;
    assign dmem_be    = be_c;
    assign mem_stall  = stall_c;
    assign misalign   = misaligned_c & rst_n;

    // MEM/WB next state: bubble while stalled, otherwise capture the instruction
    always_comb begin
        alu_d   = alu_q;
        pc4_d   = pc4_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        wen_d   = 1'b0;
        if (!stall_c) begin
            alu_d  = ALU_out_EXMEM;
            pc4_d  = pc_4_EXMEM;
            f3_d   = funct3_EXMEM;
            off_d  = off_c;
            ctrl_d = reg_wr_ctrl_EXMEM;
            rd_d   = rd_EXMEM;
            wen_d  = valid_EXMEM & reg_wr_en_EXMEM & ~mem_wr_en_EXMEM & ~misaligned_c;
            if (complete_c && !mem_wr_en_EXMEM) begin
                rdata_d = dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q   <= '0;
            pc4_q   <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            pc4_q   <= pc4_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
        end
    end

    assign ALU_out_MEMWB     = alu_q;
    assign pc_4_MEMWB        = pc4_q;
    assign mem_rd_data_MEMWB = rdata_q;
    assign funct3_MEMWB      = f3_q;
    assign byte_offset_MEMWB = off_q;
    assign reg_wr_ctrl_MEMWB = ctrl_q;
    assign rd_MEMWB          = rd_q;
    assign reg_wr_en_MEMWB   = wen_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: stores, loads with wait states,
// misalignment, non-memory pass-through, back-to-back accesses and mid-WAIT reset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_EXMEM;
    logic [31:0] ALU_out_EXMEM;
    logic [31:0] rs2_data_EXMEM;
    logic [31:0] pc_4_EXMEM;
    logic [2:0]  funct3_EXMEM;
    logic        mem_rd_en_EXMEM;
    logic        mem_wr_en_EXMEM;
    logic [1:0]  reg_wr_ctrl_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        reg_wr_en_EXMEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        misalign;
    logic [31:0] ALU_out_MEMWB;
    logic [31:0] pc_4_MEMWB;
    logic [31:0] mem_rd_data_MEMWB;
    logic [2:0]  funct3_MEMWB;
    logic [1:0]  byte_offset_MEMWB;
    logic [1:0]  reg_wr_ctrl_MEMWB;
    logic [4:0]  rd_MEMWB;
    logic        reg_wr_en_MEMWB;

    int checks = 0;
    int errors = 0;

    mem_access #(.WIDTH(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_EXMEM       (valid_EXMEM),
        .ALU_out_EXMEM     (ALU_out_EXMEM),
        .rs2_data_EXMEM    (rs2_data_EXMEM),
        .pc_4_EXMEM        (pc_4_EXMEM),
        .funct3_EXMEM      (funct3_EXMEM),
        .mem_rd_en_EXMEM   (mem_rd_en_EXMEM),
        .mem_wr_en_EXMEM   (mem_wr_en_EXMEM),
        .reg_wr_ctrl_EXMEM (reg_wr_ctrl_EXMEM),
        .rd_EXMEM          (rd_EXMEM),
        .reg_wr_en_EXMEM   (reg_wr_en_EXMEM),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_ready        (dmem_ready),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .misalign          (misalign),
        .ALU_out_MEMWB     (ALU_out_MEMWB),
        .pc_4_MEMWB        (pc_4_MEMWB),
        .mem_rd_data_MEMWB (mem_rd_data_MEMWB),
        .funct3_MEMWB      (funct3_MEMWB),
        .byte_offset_MEMWB (byte_offset_MEMWB),
        .reg_wr_ctrl_MEMWB (reg_wr_ctrl_MEMWB),
        .rd_MEMWB          (rd_MEMWB),
        .reg_wr_en_MEMWB   (reg_wr_en_MEMWB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] pc4, input logic [2:0] f3, input logic rd_en,
                         input logic wr_en, input logic [1:0] ctrl, input logic [4:0] rd,
                         input logic wen, input logic rdy, input logic [31:0] rdat);
        valid_EXMEM       = v;
        ALU_out_EXMEM     = alu;
        rs2_data_EXMEM    = rs2;
        pc_4_EXMEM        = pc4;
        funct3_EXMEM      = f3;
        mem_rd_en_EXMEM   = rd_en;
        mem_wr_en_EXMEM   = wr_en;
        reg_wr_ctrl_EXMEM = ctrl;
        rd_EXMEM          = rd;
        reg_wr_en_EXMEM   = wen;
        dmem_ready        = rdy;
        dmem_rdata        = rdat;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_wen", reg_wr_en_MEMWB, 0);
        chk("rst_alu", ALU_out_MEMWB, 0);
        chk("rst_rdata", mem_rd_data_MEMWB, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // SW 0xDEADBEEF to 0x100, zero wait
        drive(1'b1, 32'h100, 32'hDEADBEEF, 32'h4, 3'b010, 1'b0, 1'b1, 2'd0, 5'd3, 1'b1, 1'b1, 32'h0);
        #1;
        chk("sw_req", dmem_req, 1);
        chk("sw_we", dmem_we, 1);
        chk("sw_addr", dmem_addr, 32'h100);
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("sw_wen", reg_wr_en_MEMWB, 0);
        chk("sw_alu", ALU_out_MEMWB, 32'h100);

        // SB 0xA5 to 0x103
        @(negedge clk);
        drive(1'b1, 32'h103, 32'h000000A5, 32'h8, 3'b000, 1'b0, 1'b1, 2'd0, 5'd4, 1'b1, 1'b1, 32'h0);
        #1;
        chk("sb_be", dmem_be, 4'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_stall", mem_stall, 0);

        // LH at 0x202 with three wait states
        @(negedge clk);
        drive(1'b1, 32'h202, 32'h0, 32'hC, 3'b001, 1'b1, 1'b0, 2'd2, 5'd9, 1'b1, 1'b0, 32'hFFFF0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lh_wait_req", dmem_req, 1);
            chk("lh_wait_stall", mem_stall, 1);
            chk("lh_wait_addr", dmem_addr, 32'h200);
            @(posedge clk); #1;
            chk("lh_bubble", reg_wr_en_MEMWB, 0);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80011234;
        #1;
        chk("lh_done_req", dmem_req, 1);
        chk("lh_done_stall", mem_stall, 0);
        chk("lh_we", dmem_we, 0);
        chk("lh_be", dmem_be, 4'b1111);
        @(posedge clk); #1;
        chk("lh_rdata", mem_rd_data_MEMWB, 32'h80011234);
        chk("lh_off", byte_offset_MEMWB, 2);
        chk("lh_f3", funct3_MEMWB, 3'b001);
        chk("lh_ctrl", reg_wr_ctrl_MEMWB, 2);
        chk("lh_rd", rd_MEMWB, 9);
        chk("lh_wen", reg_wr_en_MEMWB, 1);

        // LW at 0x305 is misaligned
        @(negedge clk);
        drive(1'b1, 32'h305, 32'h0, 32'h10, 3'b010, 1'b1, 1'b0, 2'd2, 5'd5, 1'b1, 1'b1, 32'h0BADF00D);
        #1;
        chk("mis_req", dmem_req, 0);
        chk("mis_pulse", misalign, 1);
        chk("mis_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("mis_wen", reg_wr_en_MEMWB, 0);
        chk("mis_rdata_hold", mem_rd_data_MEMWB, 32'h80011234);

        // ADD: ready high without a request must be ignored
        @(negedge clk);
        drive(1'b1, 32'h55, 32'h0, 32'h14, 3'b000, 1'b0, 1'b0, 2'd0, 5'd7, 1'b1, 1'b1, 32'hFFFFFFFF);
        #1;
        chk("add_misalign", misalign, 0);
        chk("add_req", dmem_req, 0);
        chk("add_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("add_alu", ALU_out_MEMWB, 32'h55);
        chk("add_ctrl", reg_wr_ctrl_MEMWB, 0);
        chk("add_rd", rd_MEMWB, 7);
        chk("add_wen", reg_wr_en_MEMWB, 1);
        chk("add_rdata_hold", mem_rd_data_MEMWB, 32'h80011234);

        // JAL
        @(negedge clk);
        drive(1'b1, 32'h1000, 32'h0, 32'h44, 3'b000, 1'b0, 1'b0, 2'd1, 5'd1, 1'b1, 1'b0, 32'h0);
        #1;
        chk("jal_req", dmem_req, 0);
        @(posedge clk); #1;
        chk("jal_pc4", pc_4_MEMWB, 32'h44);
        chk("jal_ctrl", reg_wr_ctrl_MEMWB, 1);
        chk("jal_rd", rd_MEMWB, 1);
        chk("jal_wen", reg_wr_en_MEMWB, 1);

        // Back-to-back zero-wait loads
        @(negedge clk);
        drive(1'b1, 32'h400, 32'h0, 32'h48, 3'b010, 1'b1, 1'b0, 2'd2, 5'd10, 1'b1, 1'b1, 32'h11111111);
        #1;
        chk("b2b0_req", dmem_req, 1);
        @(posedge clk); #1;
        chk("b2b0_rdata", mem_rd_data_MEMWB, 32'h11111111);
        @(negedge clk);
        drive(1'b1, 32'h404, 32'h0, 32'h4C, 3'b010, 1'b1, 1'b0, 2'd2, 5'd11, 1'b1, 1'b1, 32'h22222222);
        #1;
        chk("b2b1_req", dmem_req, 1);
        chk("b2b1_addr", dmem_addr, 32'h404);
        @(posedge clk); #1;
        chk("b2b1_rdata", mem_rd_data_MEMWB, 32'h22222222);
        chk("b2b1_rd", rd_MEMWB, 11);

        // Bubble for an invalid slot
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b010, 1'b0, 1'b0, 2'd0, 5'd12, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("inv_wen", reg_wr_en_MEMWB, 0);

        // Load enters WAIT, then reset mid-WAIT
        @(negedge clk);
        drive(1'b1, 32'h500, 32'h0, 32'h50, 3'b010, 1'b1, 1'b0, 2'd2, 5'd13, 1'b1, 1'b0, 32'h0);
        #1;
        chk("wr_stall", mem_stall, 1);
        @(posedge clk); #2;
        chk("wr_wait_req", dmem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("wr_rst_req", dmem_req, 0);
        chk("wr_rst_stall", mem_stall, 0);
        chk("wr_rst_alu", ALU_out_MEMWB, 0);
        chk("wr_rst_rdata", mem_rd_data_MEMWB, 0);
        chk("wr_rst_pc4", pc_4_MEMWB, 0);
        chk("wr_rst_rd", rd_MEMWB, 0);
        @(negedge clk);
        valid_EXMEM     = 1'b0;
        mem_rd_en_EXMEM = 1'b0;
        rst_n           = 1'b1;
        #1;
        chk("post_rst_req", dmem_req, 0);
        chk("post_rst_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("post_rst_req2", dmem_req, 0);

        // FSM back in IDLE: fresh load completes in one cycle
        @(negedge clk);
        drive(1'b1, 32'h600, 32'h0, 32'h54, 3'b100, 1'b1, 1'b0, 2'd2, 5'd14, 1'b1, 1'b1, 32'h00000033);
        #1;
        chk("idle_req", dmem_req, 1);
        chk("idle_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("idle_rdata", mem_rd_data_MEMWB, 32'h33);
        chk("idle_wen", reg_wr_en_MEMWB, 1);
        chk("idle_f3", funct3_MEMWB, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
